// File: rtl/riscv_fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC and fetches one instruction at a time
// over a request/response handshake. It holds each word until execute retires it.
module riscv_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            retire,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opCode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] next_pc;

  // Next-PC select; all sums wrap modulo 2^XLEN. Select 11 behaves like 00.
  function automatic logic [XLEN-1:0] calc_next_pc(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] cur_pc,
    input logic [XLEN-1:0] offset,
    input logic [XLEN-1:0] target
  );
    logic [XLEN-1:0] result;
    case (sel)
      2'b01:   result = cur_pc + offset;
      2'b10:   result = target & ~XLEN'(1);
      default: result = cur_pc + XLEN'(4);
    endcase
    return result;
  endfunction

  assign next_pc = calc_next_pc(pc_src, pc_q, imm, alu_result);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    err_d    = err_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (retire) begin
          vld_d   = 1'b0;
          instr_d = NOP_INSTR;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Fields slice the held word; it is NOP whenever no valid instruction is held.
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + XLEN'(4);
  assign instr        = instr_q;
  assign instr_valid  = vld_q;
  assign misalign_err = err_q;
  assign opCode       = instr_q[6:0];
  assign func3        = instr_q[14:12];
  assign func7        = instr_q[31:25];

endmodule

// File: tb/tb_riscv_fetch_unit.sv
`timescale 1ns/1ps
// Bench for riscv_fetch_unit: directed scenarios plus randomized fetch/retire
// traffic, checked against a PC/instruction reference model.
module tb_riscv_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        retire;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opCode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int compares = 0;
  int fails    = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .retire       (retire),
    .pc_src       (pc_src),
    .imm          (imm),
    .alu_result   (alu_result),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .opCode       (opCode),
    .func3        (func3),
    .func7        (func7),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC rule, written as plain modular arithmetic.
  function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] p,
                                             input logic [31:0] off, input logic [31:0] tgt);
    longint s;
    case (sel)
      2'b01:   s = longint'(p) + longint'(off);
      2'b10:   s = (longint'(tgt) / 2) * 2;
      default: s = longint'(p) + 4;
    endcase
    return s[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_opcode"}, {25'd0, opCode}, 32'h13);
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  // Waits for the request pulse, answers after lat WAIT cycles.
  task automatic do_fetch(input logic [31:0] word, input int lat, input bit spur);
    int n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_pc);
    chk("req_plus4", pc_plus4, exp_pc + 32'd4);
    check_idle_outputs("req");
    if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end
    step();
    imem_rvalid = 1'b0;
    chk("req_single_pulse", {31'd0, imem_req}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_req", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    exp_instr   = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("got_valid", {31'd0, instr_valid}, 32'd1);
    chk("got_instr", instr, exp_instr);
    chk("got_opcode", {25'd0, opCode}, {25'd0, exp_instr[6:0]});
    chk("got_func3", {29'd0, func3}, {29'd0, exp_instr[14:12]});
    chk("got_func7", {25'd0, func7}, {25'd0, exp_instr[31:25]});
    chk("got_pc", pc, exp_pc);
  endtask

  task automatic do_retire(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] tgt,
                           input int hold, input bit spur);
    logic [31:0] nxt;
    for (int i = 0; i < hold; i++) begin
      if (spur) begin
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
      end
      step();
      imem_rvalid = 1'b0;
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, exp_instr);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    pc_src     = sel;
    imm        = off;
    alu_result = tgt;
    retire     = 1'b1;
    nxt        = model_next(sel, exp_pc, off, tgt);
    step();
    retire     = 1'b0;
    pc_src     = 2'($urandom);
    imm        = $urandom;
    alu_result = $urandom;
    if (nxt % 4 == 0) begin
      exp_pc = nxt;
      chk("ret_req", {31'd0, imem_req}, 32'd1);
      chk("ret_addr", imem_addr, exp_pc);
      chk("ret_err", {31'd0, misalign_err}, 32'd0);
      check_idle_outputs("ret");
    end else begin
      chk("halt_err", {31'd0, misalign_err}, 32'd1);
      check_idle_outputs("halt");
      for (int i = 0; i < 6; i++) begin
        retire      = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
        step();
        chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", pc, exp_pc);
        chk("halt_sticky", {31'd0, misalign_err}, 32'd1);
      end
      retire      = 1'b0;
      imem_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    retire      = 1'b0;
    pc_src      = 2'b00;
    imm         = '0;
    alu_result  = '0;
    exp_pc      = 32'h0;
    exp_instr   = NOP;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // addi x1,x0,5 with 1-cycle latency, held, then sequential advance
    do_fetch(32'h0050_0093, 1, 1'b0);
    do_retire(2'b00, 32'h0, 32'h0, 5, 1'b0);
    chk("seq_pc4", pc, 32'h4);

    // jump to 8, then branch back by -8
    do_fetch($urandom, 2, 1'b0);
    do_retire(2'b10, 32'h0, 32'h8, 0, 1'b0);
    do_fetch($urandom, 1, 1'b0);
    do_retire(2'b01, 32'hFFFF_FFF8, 32'h0, 1, 1'b0);
    chk("branch_back_pc", pc, 32'h0);

    // top of address space wraps
    do_fetch($urandom, 1, 1'b0);
    do_retire(2'b10, 32'h0, 32'hFFFF_FFFC, 0, 1'b0);
    do_fetch($urandom, 3, 1'b0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    do_retire(2'b00, 32'h0, 32'h0, 0, 1'b0);
    chk("wrap_pc", pc, 32'h0);

    // long latency with spurious rvalid in REQ and VALID; reserved select
    do_fetch(32'hFE00_0EE3, 7, 1'b1);
    do_retire(2'b11, $urandom, $urandom, 4, 1'b1);
    chk("sel11_pc", pc, 32'h4);

    // jalr with odd target is aligned after clearing bit0
    do_fetch($urandom, 1, 1'b0);
    do_retire(2'b10, 32'h0, 32'h0000_0101, 0, 1'b0);
    chk("jalr_pc", pc, 32'h100);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] off;
      logic [31:0] tgt;
      off = $urandom & 32'hFFFF_FFFC;
      tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      do_fetch($urandom, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      do_retire(2'($urandom_range(0, 3)), off, tgt, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // misaligned jalr target halts
    do_fetch($urandom, 1, 1'b0);
    do_retire(2'b10, 32'h0, 32'h0000_0102, 0, 1'b0);

    // reset clears the sticky error
    rst_n  = 1'b0;
    exp_pc = 32'h0;
    #1;
    chk("rst2_err", {31'd0, misalign_err}, 32'd0);
    check_idle_outputs("rst2");
    step();
    rst_n = 1'b1;
    do_fetch($urandom, 1, 1'b0);
    do_retire(2'b00, 32'h0, 32'h0, 0, 1'b0);
    step();
    chk("midwait_req", {31'd0, imem_req}, 32'd0);
    chk("midwait_pc", pc, 32'h4);

    // asynchronous reset in the middle of WAIT
    #3;
    rst_n  = 1'b0;
    exp_pc = 32'h0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_err", {31'd0, misalign_err}, 32'd0);
    check_idle_outputs("async");
    step();
    rst_n = 1'b1;
    do_fetch(32'h0050_0093, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
